// File: rtl/mpc_multi_ch_scheduler_if.sv
// Compute-chain handshake between the multi-channel scheduler (master) and
// the shared Kalman/MPC chain (slave).
interface mpc_multi_ch_scheduler_if #(
    parameter int WORD_SIZE = 32,
    parameter int CH_W      = 1
);
    logic [WORD_SIZE-1:0] o_calc_Vpv;
    logic [WORD_SIZE-1:0] o_calc_Vout;
    logic [WORD_SIZE-1:0] o_calc_DC;
    logic [CH_W-1:0]      o_calc_ch;
    logic                 o_calc_begin;
    logic                 i_calc_DV;
    logic [WORD_SIZE-1:0] i_calc_DC;

    modport master (
        output o_calc_Vpv, o_calc_Vout, o_calc_DC, o_calc_ch, o_calc_begin,
        input  i_calc_DV, i_calc_DC
    );

    modport slave (
        input  o_calc_Vpv, o_calc_Vout, o_calc_DC, o_calc_ch, o_calc_begin,
        output i_calc_DV, i_calc_DC
    );
endinterface

// File: rtl/mpc_multi_ch_scheduler.sv
// Samples N_CH converter channels on a period tick, dispatches them one at a
// time to a shared compute chain and holds a clamped duty register per channel.
module mpc_multi_ch_scheduler #(
    parameter int                   WORD_SIZE     = 32,
    parameter int                   N_CH          = 2,
    parameter int                   SAMPLE_PERIOD = 75,
    parameter int                   TIMEOUT       = 60,
    parameter logic [WORD_SIZE-1:0] DC_INIT       = 32'h0001_0000,
    parameter logic [WORD_SIZE-1:0] DC_MIN        = 32'h0000_0000,
    parameter logic [WORD_SIZE-1:0] DC_MAX        = 32'h0001_0000
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_clear,
    input  logic [N_CH*WORD_SIZE-1:0]   i_Vpv,
    input  logic [N_CH*WORD_SIZE-1:0]   i_Vout,
    mpc_multi_ch_scheduler_if.master    calc,
    output logic [N_CH*WORD_SIZE-1:0]   o_MPC_DC,
    output logic [N_CH-1:0]             o_DC_valid,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic                        o_timeout
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT} state_t;

    state_t                             r_state, w_next;
    logic [CNT_W-1:0]                   r_cnt;
    logic [TMR_W-1:0]                   r_tmr;
    logic [CH_W-1:0]                    r_ch;
    logic [N_CH-1:0][WORD_SIZE-1:0]     r_snap_vpv, r_snap_vout, r_dc;
    logic [N_CH-1:0]                    r_dc_valid;
    logic [WORD_SIZE-1:0]               r_calc_vpv, r_calc_vout, r_calc_dc;
    logic [CH_W-1:0]                    r_calc_ch;
    logic                               r_calc_begin, r_overrun, r_timeout;

    logic [N_CH-1:0][WORD_SIZE-1:0]     w_vpv_in, w_vout_in;
    logic                               w_tick, w_tmo, w_last;
    logic                               w_load, w_wr, w_tmo_hit;
    logic [CH_W-1:0]                    w_load_ch;
    logic [WORD_SIZE-1:0]               w_src_vpv, w_src_vout, w_clamped;

    assign w_vpv_in  = i_Vpv;
    assign w_vout_in = i_Vout;
    assign w_tick    = i_enable && (r_cnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign w_tmo     = (r_tmr == TMR_W'(TIMEOUT - 1));
    assign w_last    = (r_ch == CH_W'(N_CH - 1));

    assign w_clamped = ($signed(calc.i_calc_DC) > $signed(DC_MAX)) ? DC_MAX :
                       ($signed(calc.i_calc_DC) < $signed(DC_MIN)) ? DC_MIN :
                       calc.i_calc_DC;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_tick) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (calc.i_calc_DV || w_tmo) w_next = S_NEXT;
            S_NEXT:   w_next = w_last ? S_IDLE : S_LAUNCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // Channel 0 launches straight from the live inputs, since the snapshot
    // is written on the same edge.
    always_comb begin
        w_load     = 1'b0;
        w_load_ch  = r_ch;
        w_wr       = 1'b0;
        w_tmo_hit  = 1'b0;
        w_src_vpv  = r_snap_vpv[r_ch];
        w_src_vout = r_snap_vout[r_ch];
        case (r_state)
            S_IDLE: if (w_tick) begin
                w_load     = 1'b1;
                w_load_ch  = '0;
                w_src_vpv  = w_vpv_in[0];
                w_src_vout = w_vout_in[0];
            end
            S_WAIT: begin
                if (calc.i_calc_DV) w_wr      = 1'b1;
                else if (w_tmo)     w_tmo_hit = 1'b1;
            end
            S_NEXT: if (!w_last) begin
                w_load     = 1'b1;
                w_load_ch  = r_ch + 1'b1;
                w_src_vpv  = r_snap_vpv[w_load_ch];
                w_src_vout = r_snap_vout[w_load_ch];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_cnt <= '0;
        else if (!i_enable || w_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ch         <= '0;
            r_tmr        <= '0;
            r_snap_vpv   <= '0;
            r_snap_vout  <= '0;
            r_dc         <= {N_CH{DC_INIT}};
            r_dc_valid   <= '0;
            r_calc_vpv   <= '0;
            r_calc_vout  <= '0;
            r_calc_dc    <= '0;
            r_calc_ch    <= '0;
            r_calc_begin <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_calc_begin <= w_load;
            r_dc_valid   <= '0;
            if (w_load) begin
                r_ch        <= w_load_ch;
                r_tmr       <= '0;
                r_calc_vpv  <= w_src_vpv;
                r_calc_vout <= w_src_vout;
                r_calc_dc   <= r_dc[w_load_ch];
                r_calc_ch   <= w_load_ch;
            end else if (r_state == S_LAUNCH || r_state == S_WAIT) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (r_state == S_IDLE && w_tick) begin
                r_snap_vpv  <= i_Vpv;
                r_snap_vout <= i_Vout;
            end
            if (w_wr) begin
                r_dc[r_ch]       <= w_clamped;
                r_dc_valid[r_ch] <= 1'b1;
            end
            // Set beats clear when both land in the same cycle.
            if (w_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            else if (i_clear)                r_overrun <= 1'b0;
            if (w_tmo_hit)    r_timeout <= 1'b1;
            else if (i_clear) r_timeout <= 1'b0;
        end
    end

    assign calc.o_calc_Vpv   = r_calc_vpv;
    assign calc.o_calc_Vout  = r_calc_vout;
    assign calc.o_calc_DC    = r_calc_dc;
    assign calc.o_calc_ch    = r_calc_ch;
    assign calc.o_calc_begin = r_calc_begin;
    assign o_MPC_DC          = r_dc;
    assign o_DC_valid        = r_dc_valid;
    assign o_busy            = (r_state != S_IDLE);
    assign o_overrun         = r_overrun;
    assign o_timeout         = r_timeout;
endmodule

// File: tb/tb_mpc_multi_ch_scheduler.sv
// Directed bench: two-channel scheduler at SAMPLE_PERIOD=75 plus a second
// instance at SAMPLE_PERIOD=8 for the overrun scenario.
module tb_mpc_multi_ch_scheduler;
    localparam int          W    = 32;
    localparam logic [31:0] INIT = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr, en8, clr8;
    logic [63:0] vpv, vout, vpv8, vout8;
    logic [63:0] mpc_dc, mpc_dc8;
    logic [1:0]  dcv, dcv8;
    logic        busy, ovr, tmo, busy8, ovr8, tmo8;
    int          n_chk = 0;
    int          n_fail = 0;

    mpc_multi_ch_scheduler_if #(.WORD_SIZE(W), .CH_W(1)) calc ();
    mpc_multi_ch_scheduler_if #(.WORD_SIZE(W), .CH_W(1)) calc8 ();

    mpc_multi_ch_scheduler #(.WORD_SIZE(W), .N_CH(2), .SAMPLE_PERIOD(75), .TIMEOUT(60)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_clear(clr),
        .i_Vpv(vpv), .i_Vout(vout), .calc(calc),
        .o_MPC_DC(mpc_dc), .o_DC_valid(dcv), .o_busy(busy),
        .o_overrun(ovr), .o_timeout(tmo)
    );

    mpc_multi_ch_scheduler #(.WORD_SIZE(W), .N_CH(2), .SAMPLE_PERIOD(8), .TIMEOUT(60)) u_dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en8), .i_clear(clr8),
        .i_Vpv(vpv8), .i_Vout(vout8), .calc(calc8),
        .o_MPC_DC(mpc_dc8), .o_DC_valid(dcv8), .o_busy(busy8),
        .o_overrun(ovr8), .o_timeout(tmo8)
    );

    // Compute-chain model: DV m_lat cycles after begin, per-channel response.
    int          m_lat = 5;
    logic        m_never0 = 1'b0;
    logic [31:0] m_resp [2];
    int          m_cnt = 0;
    int          m_ch = 0;
    logic        r_mdv = 1'b0;
    logic [31:0] r_mdc = '0;
    logic        s_dv = 1'b0;
    logic [31:0] s_dc = '0;
    assign calc.i_calc_DV = r_mdv | s_dv;
    assign calc.i_calc_DC = s_dv ? s_dc : r_mdc;

    initial forever begin
        @(negedge clk);
        r_mdv = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && !(m_never0 && m_ch == 0)) begin
                r_mdv = 1'b1;
                r_mdc = m_resp[m_ch];
            end
        end
        if (calc.o_calc_begin) begin
            m_cnt = m_lat;
            m_ch  = int'(calc.o_calc_ch);
        end
    end

    int   m8_cnt = 0;
    logic r8_dv = 1'b0;
    assign calc8.i_calc_DV = r8_dv;
    assign calc8.i_calc_DC = 32'h0000_8000;

    initial forever begin
        @(negedge clk);
        r8_dv = 1'b0;
        if (m8_cnt > 0) begin
            m8_cnt--;
            if (m8_cnt == 0) r8_dv = 1'b1;
        end
        if (calc8.o_calc_begin) m8_cnt = 6;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_begin(input int max, output int n);
        n = 0;
        while (!calc.o_calc_begin && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; en8 = 1'b0; clr = 1'b0; clr8 = 1'b0;
        vpv   = {32'h0020_0000, 32'h0023_0000};
        vout  = {32'h0030_0000, 32'h0050_0000};
        vpv8  = {32'h0011_0000, 32'h0022_0000};
        vout8 = {32'h0033_0000, 32'h0044_0000};
        cyc(3);
        n_chk++; if (mpc_dc !== {INIT, INIT}) begin n_fail++; $display("FAIL reset_mpc_dc: got %h exp %h", mpc_dc, {INIT, INIT}); end
        n_chk++; if (mpc_dc8 !== {INIT, INIT}) begin n_fail++; $display("FAIL reset_mpc_dc8: got %h exp %h", mpc_dc8, {INIT, INIT}); end
        n_chk++; if ({calc.o_calc_Vpv, calc.o_calc_Vout, calc.o_calc_DC, calc.o_calc_ch, calc.o_calc_begin} !== '0) begin
            n_fail++; $display("FAIL reset_calc: got %h/%h/%h/%b/%b exp all 0", calc.o_calc_Vpv, calc.o_calc_Vout, calc.o_calc_DC, calc.o_calc_ch, calc.o_calc_begin); end
        n_chk++; if ({dcv, busy, ovr, tmo} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 00000", {dcv, busy, ovr, tmo}); end
    endtask

    task automatic test_first_launch;
        int n;
        m_lat = 5; m_resp[0] = 32'h0000_8000; m_resp[1] = 32'h0000_C000;
        rst_n = 1'b1; en = 1'b1;
        wait_begin(100, n);
        n_chk++; if (n != 75) begin n_fail++; $display("FAIL first_begin_cycle: got %0d exp 75", n); end
        n_chk++; if (calc.o_calc_ch !== 1'b0 || calc.o_calc_Vpv !== 32'h0023_0000 || calc.o_calc_Vout !== 32'h0050_0000 || calc.o_calc_DC !== INIT) begin
            n_fail++; $display("FAIL first_launch_data: got ch=%b vpv=%h vout=%h dc=%h exp ch=0 vpv=00230000 vout=00500000 dc=%h", calc.o_calc_ch, calc.o_calc_Vpv, calc.o_calc_Vout, calc.o_calc_DC, INIT); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b exp 1", busy); end
    endtask

    task automatic test_dc_update;
        cyc(5);
        n_chk++; if (dcv !== 2'b00 || mpc_dc[31:0] !== INIT || calc.o_calc_Vpv !== 32'h0023_0000) begin
            n_fail++; $display("FAIL upd_pre_dv: got dcv=%b dc0=%h vpv=%h exp 00 %h 00230000", dcv, mpc_dc[31:0], calc.o_calc_Vpv, INIT); end
        cyc(1);
        n_chk++; if (dcv !== 2'b01 || mpc_dc[31:0] !== 32'h0000_8000) begin
            n_fail++; $display("FAIL upd_ch0: got dcv=%b dc0=%h exp 01 00008000", dcv, mpc_dc[31:0]); end
        cyc(1);
        n_chk++; if (dcv !== 2'b00 || calc.o_calc_begin !== 1'b1 || calc.o_calc_ch !== 1'b1 || calc.o_calc_Vpv !== 32'h0020_0000 || calc.o_calc_Vout !== 32'h0030_0000 || calc.o_calc_DC !== INIT) begin
            n_fail++; $display("FAIL upd_launch_ch1: got dcv=%b beg=%b ch=%b vpv=%h vout=%h dc=%h exp 00 1 1 00200000 00300000 %h", dcv, calc.o_calc_begin, calc.o_calc_ch, calc.o_calc_Vpv, calc.o_calc_Vout, calc.o_calc_DC, INIT); end
        cyc(6);
        n_chk++; if (dcv !== 2'b10 || mpc_dc !== {32'h0000_C000, 32'h0000_8000}) begin
            n_fail++; $display("FAIL upd_ch1: got dcv=%b dc=%h exp 10 0000c00000008000", dcv, mpc_dc); end
        cyc(1);
        n_chk++; if (dcv !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL upd_idle: got dcv=%b busy=%b exp 00 0", dcv, busy); end
    endtask

    task automatic test_clamp;
        int n;
        m_resp[0] = 32'h0002_0000; m_resp[1] = 32'hFFFF_0000;
        vpv[31:0] = 32'h0024_0000;
        wait_begin(100, n);
        n_chk++; if (calc.o_calc_begin !== 1'b1 || calc.o_calc_DC !== 32'h0000_8000 || calc.o_calc_Vpv !== 32'h0024_0000) begin
            n_fail++; $display("FAIL clamp_launch0: got beg=%b dc=%h vpv=%h exp 1 00008000 00240000", calc.o_calc_begin, calc.o_calc_DC, calc.o_calc_Vpv); end
        cyc(7);
        n_chk++; if (calc.o_calc_begin !== 1'b1 || calc.o_calc_DC !== 32'h0000_C000 || mpc_dc[31:0] !== 32'h0001_0000) begin
            n_fail++; $display("FAIL clamp_high: got beg=%b calc_dc=%h dc0=%h exp 1 0000c000 00010000", calc.o_calc_begin, calc.o_calc_DC, mpc_dc[31:0]); end
        cyc(6);
        n_chk++; if (dcv !== 2'b10 || mpc_dc !== {32'h0000_0000, 32'h0001_0000}) begin
            n_fail++; $display("FAIL clamp_low: got dcv=%b dc=%h exp 10 0000000000010000", dcv, mpc_dc); end
        cyc(1);
    endtask

    task automatic test_timeout;
        int n;
        m_never0 = 1'b1; m_resp[1] = 32'h0000_4000;
        wait_begin(100, n);
        n_chk++; if (calc.o_calc_begin !== 1'b1 || calc.o_calc_ch !== 1'b0) begin
            n_fail++; $display("FAIL tmo_launch: got beg=%b ch=%b exp 1 0", calc.o_calc_begin, calc.o_calc_ch); end
        cyc(59);
        n_chk++; if (tmo !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got tmo=%b busy=%b exp 0 1", tmo, busy); end
        cyc(1);
        n_chk++; if (tmo !== 1'b1 || mpc_dc[31:0] !== 32'h0001_0000 || dcv !== 2'b00) begin
            n_fail++; $display("FAIL tmo_set: got tmo=%b dc0=%h dcv=%b exp 1 00010000 00", tmo, mpc_dc[31:0], dcv); end
        cyc(1);
        n_chk++; if (calc.o_calc_begin !== 1'b1 || calc.o_calc_ch !== 1'b1) begin
            n_fail++; $display("FAIL tmo_next_ch: got beg=%b ch=%b exp 1 1", calc.o_calc_begin, calc.o_calc_ch); end
        cyc(6);
        n_chk++; if (dcv !== 2'b10 || mpc_dc[63:32] !== 32'h0000_4000 || tmo !== 1'b1) begin
            n_fail++; $display("FAIL tmo_ch1_upd: got dcv=%b dc1=%h tmo=%b exp 10 00004000 1", dcv, mpc_dc[63:32], tmo); end
        clr = 1'b1; cyc(1); clr = 1'b0;
        n_chk++; if (tmo !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got tmo=%b ovr=%b exp 0 0", tmo, ovr); end
        m_never0 = 1'b0;
    endtask

    task automatic test_enable_gate;
        int n, bad;
        m_resp[0] = 32'h0000_6000; m_resp[1] = 32'h0000_7000;
        wait_begin(100, n);
        cyc(2); en = 1'b0;
        cyc(4);
        n_chk++; if (dcv !== 2'b01 || mpc_dc[31:0] !== 32'h0000_6000) begin
            n_fail++; $display("FAIL en_ch0: got dcv=%b dc0=%h exp 01 00006000", dcv, mpc_dc[31:0]); end
        cyc(7);
        n_chk++; if (dcv !== 2'b10 || mpc_dc !== {32'h0000_7000, 32'h0000_6000}) begin
            n_fail++; $display("FAIL en_ch1: got dcv=%b dc=%h exp 10 0000700000006000", dcv, mpc_dc); end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (calc.o_calc_begin || busy) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL en_quiet: got %0d active cycles exp 0", bad); end
        s_dc = 32'h0000_1234; s_dv = 1'b1; cyc(1); s_dv = 1'b0;
        n_chk++; if (dcv !== 2'b00 || mpc_dc !== {32'h0000_7000, 32'h0000_6000}) begin
            n_fail++; $display("FAIL stray_dv: got dcv=%b dc=%h exp 00 0000700000006000", dcv, mpc_dc); end
        cyc(1);
        n_chk++; if (mpc_dc !== {32'h0000_7000, 32'h0000_6000} || ovr !== 1'b0 || tmo !== 1'b0) begin
            n_fail++; $display("FAIL stray_hold: got dc=%h ovr=%b tmo=%b exp 0000700000006000 0 0", mpc_dc, ovr, tmo); end
    endtask

    task automatic test_overrun;
        int n;
        en8 = 1'b1; n = 0;
        while (!calc8.o_calc_begin && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_chk++; if (n != 8 || calc8.o_calc_Vpv !== 32'h0022_0000) begin
            n_fail++; $display("FAIL ovr_first: got cyc=%0d vpv=%h exp 8 00220000", n, calc8.o_calc_Vpv); end
        vpv8  = {32'h0055_0000, 32'h0066_0000};
        vout8 = {32'h0077_0000, 32'h0088_0000};
        cyc(7);
        n_chk++; if (ovr8 !== 1'b0 || dcv8 !== 2'b01) begin n_fail++; $display("FAIL ovr_pre: got ovr=%b dcv=%b exp 0 01", ovr8, dcv8); end
        cyc(1);
        n_chk++; if (ovr8 !== 1'b1 || calc8.o_calc_begin !== 1'b1 || calc8.o_calc_ch !== 1'b1 || calc8.o_calc_Vpv !== 32'h0011_0000 || calc8.o_calc_Vout !== 32'h0033_0000) begin
            n_fail++; $display("FAIL ovr_snapshot: got ovr=%b beg=%b ch=%b vpv=%h vout=%h exp 1 1 1 00110000 00330000", ovr8, calc8.o_calc_begin, calc8.o_calc_ch, calc8.o_calc_Vpv, calc8.o_calc_Vout); end
        cyc(8);
        n_chk++; if (calc8.o_calc_begin !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL ovr_dropped_tick: got beg=%b busy=%b exp 0 0", calc8.o_calc_begin, busy8); end
        cyc(8);
        n_chk++; if (calc8.o_calc_begin !== 1'b1 || calc8.o_calc_ch !== 1'b0 || calc8.o_calc_Vpv !== 32'h0066_0000) begin
            n_fail++; $display("FAIL ovr_resample: got beg=%b ch=%b vpv=%h exp 1 0 00660000", calc8.o_calc_begin, calc8.o_calc_ch, calc8.o_calc_Vpv); end
        clr8 = 1'b1; cyc(1); clr8 = 1'b0;
        n_chk++; if (ovr8 !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b exp 0", ovr8); end
        cyc(6);
        clr8 = 1'b1; cyc(1); clr8 = 1'b0;
        n_chk++; if (ovr8 !== 1'b1 || tmo8 !== 1'b0) begin
            n_fail++; $display("FAIL ovr_set_wins: got ovr=%b tmo=%b exp 1 0", ovr8, tmo8); end
    endtask

    initial begin
        test_reset();
        test_first_launch();
        test_dc_update();
        test_clamp();
        test_timeout();
        test_enable_gate();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
